// File: rtl/inv_filter_ej_4_if.sv
// inv_filter_ej_4_if: sample stream bundle between a producer and the inverse filter
interface inv_filter_ej_4_if #(
    parameter int NB_DATA = 16
);
    logic signed [NB_DATA-1:0] i_y;
    logic                      i_valid;
    logic                      o_ready;
    logic                      i_clear;
    logic signed [NB_DATA-1:0] o_x;
    logic                      o_valid;
    logic                      o_sat;

    modport master (
        output i_y, i_valid, i_clear,
        input  o_ready, o_x, o_valid, o_sat
    );

    modport slave (
        input  i_y, i_valid, i_clear,
        output o_ready, o_x, o_valid, o_sat
    );
endinterface

// File: rtl/inv_filter_ej_4.sv
// inv_filter_ej_4: IIR inverse of the forward filter, one shared adder sequenced over six terms
module inv_filter_ej_4 #(
    parameter int NB_DATA = 16
) (
    input logic              clock,
    input logic              i_rst,
    inv_filter_ej_4_if.slave bus
);
    localparam int NB_ACC = NB_DATA + 3;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    localparam logic signed [NB_ACC-1:0] MAX_X = {4'b0000, {(NB_DATA-1){1'b1}}};
    localparam logic signed [NB_ACC-1:0] MIN_X = {4'b1111, {(NB_DATA-1){1'b0}}};

    logic [1:0]                state;
    logic [2:0]                cnt;
    logic signed [NB_ACC-1:0]  acc;
    logic signed [NB_ACC-1:0]  term;
    logic signed [NB_ACC-1:0]  acc_sum;
    logic signed [NB_DATA-1:0] y0, y1, y2;
    logic signed [NB_DATA-1:0] x1, x2, x3;
    logic signed [NB_DATA-1:0] x_sat;
    logic                      clip_hi;
    logic                      clip_lo;

    function automatic logic signed [NB_ACC-1:0] sx(input logic signed [NB_DATA-1:0] v);
        return {{3{v[NB_DATA-1]}}, v};
    endfunction

    assign bus.o_ready = (state == IDLE);

    // term selected for this ACC step: +y0, -y1/2, -y2/4, +x1, -x2, -x3
    always_comb begin
        term = '0;
        case (cnt)
            3'd0:    term = sx(y0);
            3'd1:    term = -sx(y1 >>> 1);
            3'd2:    term = -sx(y2 >>> 2);
            3'd3:    term = sx(x1);
            3'd4:    term = -sx(x2);
            3'd5:    term = -sx(x3);
            default: term = '0;
        endcase
    end

    // the single shared adder and the output clamp
    always_comb begin
        acc_sum = acc + term;
        clip_hi = acc > MAX_X;
        clip_lo = acc < MIN_X;
        x_sat   = clip_hi ? MAX_X[NB_DATA-1:0] : clip_lo ? MIN_X[NB_DATA-1:0] : acc[NB_DATA-1:0];
    end

    // sequencer: accept, accumulate six terms, then publish and shift histories
    always_ff @(posedge clock) begin
        if (i_rst || bus.i_clear) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            y0          <= '0;
            y1          <= '0;
            y2          <= '0;
            x1          <= '0;
            x2          <= '0;
            x3          <= '0;
            bus.o_sat   <= 1'b0;
            bus.o_valid <= 1'b0;
            if (i_rst)
                bus.o_x <= '0;
        end else begin
            bus.o_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_valid) begin
                        y0    <= bus.i_y;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= ACC;
                    end
                end
                ACC: begin
                    acc <= acc_sum;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd5)
                        state <= OUT;
                end
                OUT: begin
                    bus.o_x     <= x_sat;
                    bus.o_valid <= 1'b1;
                    bus.o_sat   <= bus.o_sat | clip_hi | clip_lo;
                    y2          <= y1;
                    y1          <= y0;
                    x3          <= x2;
                    x2          <= x1;
                    x1          <= x_sat;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
